// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its hazard controller.
// The performance-counter signals exist only when HAZARD_PERF_EN is defined.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2
);
  // Datapath status towards the controller
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_reg_write;
  logic                  mem_write_raw;
  logic                  mem_redirect;
  logic                  dmem_busy;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_reg_write;

  // Controls back to the datapath
  logic             pc_en;
  logic             pc_sel_redirect;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic             mem_write;
  logic             reg_write;
  logic [3:0]       valid;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    input  stall_cnt, flush_cnt, freeze_cnt,
`endif
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
    output mem_dest, mem_reg_write, mem_write_raw, mem_redirect, dmem_busy,
    output wb_dest, wb_reg_write,
    input  pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  fwd_a, fwd_b, mem_write, reg_write, valid
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    output stall_cnt, flush_cnt, freeze_cnt,
`endif
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
    input  mem_dest, mem_reg_write, mem_write_raw, mem_redirect, dmem_busy,
    input  wb_dest, wb_reg_write,
    output pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output fwd_a, fwd_b, mem_write, reg_write, valid
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Valid tracking, stall/flush/freeze sequencing and EX forwarding for a 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze cycle counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO    = '0;
  localparam logic [FWD_W-1:0]      FWD_REGFILE = FWD_W'(0);
  localparam logic [FWD_W-1:0]      FWD_MEM_WB  = FWD_W'(1);
  localparam logic [FWD_W-1:0]      FWD_EX_MEM  = FWD_W'(2);

  // What the pipeline does at the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_LOAD_USE,
    ACT_REDIRECT,
    ACT_FREEZE
  } action_t;

  action_t action;
  logic    if_id_v, id_ex_v, ex_mem_v, mem_wb_v;
  logic    redirect, freeze, load_use;
  logic    mem_live, wb_live;

  function automatic logic [FWD_W-1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] mem_dest,
    input logic [REG_ADDR_W-1:0] wb_dest,
    input logic                  mem_ok,
    input logic                  wb_ok
  );
    // The younger producer (EX/MEM) holds the newer value and wins.
    if (mem_ok && (mem_dest == src))     return FWD_EX_MEM;
    else if (wb_ok && (wb_dest == src))  return FWD_MEM_WB;
    else                                 return FWD_REGFILE;
  endfunction

  always_comb begin
    redirect = bus.mem_redirect & ex_mem_v;
    freeze   = bus.dmem_busy & ex_mem_v;
    load_use = if_id_v & id_ex_v & bus.ex_mem_read & (bus.ex_rt != REG_ZERO) &
               ((bus.id_rs == bus.ex_rt) | (bus.id_uses_rt & (bus.id_rt == bus.ex_rt)));

    if (freeze)        action = ACT_FREEZE;
    else if (redirect) action = ACT_REDIRECT;
    else if (load_use) action = ACT_LOAD_USE;
    else               action = ACT_NORMAL;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves one unassigned (no latch).
    bus.pc_en           = 1'b1;
    bus.pc_sel_redirect = 1'b0;
    bus.if_id_en        = 1'b1;
    bus.id_ex_en        = 1'b1;
    bus.ex_mem_en       = 1'b1;
    bus.mem_wb_en       = 1'b1;
    unique case (action)
      ACT_FREEZE: begin
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.id_ex_en  = 1'b0;
        bus.ex_mem_en = 1'b0;
        bus.mem_wb_en = 1'b0;
      end
      ACT_REDIRECT: bus.pc_sel_redirect = 1'b1;
      ACT_LOAD_USE: begin
        bus.pc_en    = 1'b0;
        bus.if_id_en = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_live = ex_mem_v & bus.mem_reg_write & (bus.mem_dest != REG_ZERO);
    wb_live  = mem_wb_v & bus.wb_reg_write & (bus.wb_dest != REG_ZERO);
    bus.fwd_a = FWD_REGFILE;
    bus.fwd_b = FWD_REGFILE;
    if (id_ex_v) begin
      bus.fwd_a = fwd_select(bus.ex_rs, bus.mem_dest, bus.wb_dest, mem_live, wb_live);
      bus.fwd_b = fwd_select(bus.ex_rt, bus.mem_dest, bus.wb_dest, mem_live, wb_live);
    end
  end

  assign bus.mem_write = bus.mem_write_raw & ex_mem_v & ~freeze;
  assign bus.reg_write = bus.wb_reg_write & mem_wb_v;
  assign bus.valid     = {if_id_v, id_ex_v, ex_mem_v, mem_wb_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_v  <= 1'b0;
      id_ex_v  <= 1'b0;
      ex_mem_v <= 1'b0;
      mem_wb_v <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let each stage read its predecessor's pre-edge value.
      unique case (action)
        ACT_FREEZE: begin
        end
        ACT_REDIRECT: begin
          // The redirecting instruction retires; everything younger is squashed.
          if_id_v  <= 1'b0;
          id_ex_v  <= 1'b0;
          ex_mem_v <= 1'b0;
          mem_wb_v <= ex_mem_v;
        end
        ACT_LOAD_USE: begin
          id_ex_v  <= 1'b0;
          ex_mem_v <= id_ex_v;
          mem_wb_v <= ex_mem_v;
        end
        default: begin
          if_id_v  <= 1'b1;
          id_ex_v  <= if_id_v;
          ex_mem_v <= id_ex_v;
          mem_wb_v <= ex_mem_v;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic hit);
    return (hit && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt,  action == ACT_LOAD_USE);
      flush_cnt  <= sat_inc(flush_cnt,  action == ACT_REDIRECT);
      freeze_cnt <= sat_inc(freeze_cnt, action == ACT_FREEZE);
    end
  end

  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;
  assign bus.freeze_cnt = freeze_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed vector table, multi-cycle
// sequences, then random stimulus against a stage-occupancy reference model.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_mem_read;
    logic [4:0] mem_dest;
    logic       mem_reg_write;
    logic       mem_write_raw;
    logic       mem_redirect;
    logic       dmem_busy;
    logic [4:0] wb_dest;
    logic       wb_reg_write;
  } stim_t;

  typedef struct packed {
    logic       pc_en;
    logic       pc_sel;
    logic [3:0] en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_write;
    logic       reg_write;
  } resp_t;

  typedef struct {
    string name;
    stim_t s;
    resp_t r;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   clk_run = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Stage occupancy of the reference model: 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB.
  bit   occ[4];
  vec_t vecs[$];

  always #5 clk = clk_run ? ~clk : 1'b0;

  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    bus.id_rs         = s.id_rs;
    bus.id_rt         = s.id_rt;
    bus.id_uses_rt    = s.id_uses_rt;
    bus.ex_rs         = s.ex_rs;
    bus.ex_rt         = s.ex_rt;
    bus.ex_mem_read   = s.ex_mem_read;
    bus.mem_dest      = s.mem_dest;
    bus.mem_reg_write = s.mem_reg_write;
    bus.mem_write_raw = s.mem_write_raw;
    bus.mem_redirect  = s.mem_redirect;
    bus.dmem_busy     = s.dmem_busy;
    bus.wb_dest       = s.wb_dest;
    bus.wb_reg_write  = s.wb_reg_write;
  endtask

  function automatic resp_t sample();
    resp_t r;
    r.pc_en     = bus.pc_en;
    r.pc_sel    = bus.pc_sel_redirect;
    r.en        = {bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
    r.fwd_a     = bus.fwd_a;
    r.fwd_b     = bus.fwd_b;
    r.mem_write = bus.mem_write;
    r.reg_write = bus.reg_write;
    return r;
  endfunction

  function automatic resp_t mk(input bit pc_en, input bit sel, input bit [3:0] en,
                               input bit [1:0] fa, input bit [1:0] fb, input bit mw, input bit rw);
    resp_t r;
    r = {pc_en, sel, en, fa, fb, mw, rw};
    return r;
  endfunction

  task automatic check_resp(input string tag, input resp_t got, input resp_t exp, input bit use_rw);
    check({tag, ".pc_en"},     got.pc_en,     exp.pc_en);
    check({tag, ".pc_sel"},    got.pc_sel,    exp.pc_sel);
    check({tag, ".enables"},   got.en,        exp.en);
    check({tag, ".fwd_a"},     got.fwd_a,     exp.fwd_a);
    check({tag, ".fwd_b"},     got.fwd_b,     exp.fwd_b);
    check({tag, ".mem_write"}, got.mem_write, exp.mem_write);
    if (use_rw) check({tag, ".reg_write"}, got.reg_write, exp.reg_write);
  endtask

  task automatic add_vec(input string name, input stim_t s, input resp_t r);
    vec_t v;
    v.name = name;
    v.s    = s;
    v.r    = r;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  function automatic bit [3:0] occ_bits();
    return {occ[0], occ[1], occ[2], occ[3]};
  endfunction

  // 0 normal, 1 load-use bubble, 2 redirect flush, 3 memory freeze
  function automatic int model_kind(input stim_t s);
    bit hit;
    hit = (s.id_rs == s.ex_rt) || (s.id_uses_rt && (s.id_rt == s.ex_rt));
    if (s.dmem_busy && occ[2])                                         return 3;
    if (s.mem_redirect && occ[2])                                      return 2;
    if (occ[0] && occ[1] && s.ex_mem_read && s.ex_rt != 0 && hit)      return 1;
    return 0;
  endfunction

  function automatic bit [1:0] model_fwd(input stim_t s, input logic [4:0] src);
    if (!occ[1] || src == 0) return 2'b00;
    if (occ[2] && s.mem_reg_write && s.mem_dest == src) return 2'b10;
    if (occ[3] && s.wb_reg_write && s.wb_dest == src)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic resp_t model_resp(input stim_t s);
    int    k;
    resp_t r;
    k = model_kind(s);
    case (k)
      3:       r = mk(0, 0, 4'b0000, 0, 0, 0, 0);
      2:       r = mk(1, 1, 4'b1111, 0, 0, 0, 0);
      1:       r = mk(0, 0, 4'b0111, 0, 0, 0, 0);
      default: r = mk(1, 0, 4'b1111, 0, 0, 0, 0);
    endcase
    r.fwd_a     = model_fwd(s, s.ex_rs);
    r.fwd_b     = model_fwd(s, s.ex_rt);
    r.mem_write = s.mem_write_raw && occ[2] && (k != 3);
    r.reg_write = s.wb_reg_write && occ[3];
    return r;
  endfunction

  // Stages below `first` hold; stage `first` takes a bubble (or a fresh fetch at IF/ID);
  // every later stage receives its predecessor's content.
  task automatic model_advance(input int first, input bit fetch);
    bit nxt[4];
    for (int i = 0; i < 4; i++) begin
      if (i < first)       nxt[i] = occ[i];
      else if (i == first) nxt[i] = (first == 0) ? fetch : 1'b0;
      else                 nxt[i] = occ[i-1];
    end
    occ = nxt;
  endtask

  task automatic model_step(input stim_t s);
    case (model_kind(s))
      3: ;
      2: begin
        occ[3] = occ[2];
        occ[0] = 0; occ[1] = 0; occ[2] = 0;
      end
      1:       model_advance(1, 1'b0);
      default: model_advance(0, 1'b1);
    endcase
  endtask

  // ---------------- test ----------------
  initial begin
    stim_t    s;
    resp_t    exp_r;
    bit [3:0] seq[6];

    s = '0;
    apply(s);
    #1;
    check("reset.valid", bus.valid, 4'b0000);
    check_resp("reset", sample(), mk(1, 0, 4'b1111, 0, 0, 0, 0), 1'b1);

    #11 reset = 1'b1;
    seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("fill%0d.valid", i), bus.valid, seq[i]);
      check($sformatf("fill%0d.enables", i),
            {bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 4'b1111);
      check($sformatf("fill%0d.fwd", i), {bus.fwd_a, bus.fwd_b}, 4'b0000);
    end

    // Directed table, pipeline full, clock parked low so only combinational outputs respond.
    s = '0;                                                              add_vec("idle", s, mk(1, 0, 4'hF, 0, 0, 0, 0));
    s = '0; s.ex_rs = 3; s.mem_dest = 3; s.mem_reg_write = 1; s.wb_dest = 3; s.wb_reg_write = 1;
                                                                         add_vec("fwd_pri", s, mk(1, 0, 4'hF, 2, 0, 0, 1));
    s = '0; s.ex_rs = 3; s.ex_rt = 4; s.mem_dest = 4; s.mem_reg_write = 1; s.wb_dest = 3; s.wb_reg_write = 1;
                                                                         add_vec("fwd_split", s, mk(1, 0, 4'hF, 1, 2, 0, 1));
    s = '0; s.mem_reg_write = 1; s.wb_reg_write = 1;                     add_vec("fwd_r0", s, mk(1, 0, 4'hF, 0, 0, 0, 1));
    s = '0; s.ex_rs = 6; s.mem_dest = 6; s.wb_dest = 6;                  add_vec("fwd_no_rw", s, mk(1, 0, 4'hF, 0, 0, 0, 0));
    s = '0; s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8;                 add_vec("lu_rs", s, mk(0, 0, 4'b0111, 0, 0, 0, 0));
    s = '0; s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 1; s.id_rt = 8; s.id_uses_rt = 1;
                                                                         add_vec("lu_rt", s, mk(0, 0, 4'b0111, 0, 0, 0, 0));
    s.id_uses_rt = 0;                                                    add_vec("lu_rt_unused", s, mk(1, 0, 4'hF, 0, 0, 0, 0));
    s = '0; s.ex_mem_read = 1;                                           add_vec("lu_r0", s, mk(1, 0, 4'hF, 0, 0, 0, 0));
    s = '0; s.ex_rt = 8; s.id_rs = 8;                                    add_vec("lu_no_load", s, mk(1, 0, 4'hF, 0, 0, 0, 0));
    s = '0; s.mem_write_raw = 1;                                         add_vec("mw_pass", s, mk(1, 0, 4'hF, 0, 0, 1, 0));
    s = '0; s.mem_redirect = 1; s.mem_write_raw = 1;                     add_vec("redirect", s, mk(1, 1, 4'hF, 0, 0, 1, 0));
    s = '0; s.mem_redirect = 1; s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8;
                                                                         add_vec("redir_over_lu", s, mk(1, 1, 4'hF, 0, 0, 0, 0));
    s = '0; s.dmem_busy = 1; s.mem_write_raw = 1;                        add_vec("freeze", s, mk(0, 0, 4'h0, 0, 0, 0, 0));
    s.mem_redirect = 1; s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8;     add_vec("freeze_pri", s, mk(0, 0, 4'h0, 0, 0, 0, 0));
    s = '0; s.dmem_busy = 1; s.ex_rs = 3; s.mem_dest = 3; s.mem_reg_write = 1;
                                                                         add_vec("freeze_fwd", s, mk(0, 0, 4'h0, 2, 0, 0, 0));

    clk_run = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i].s);
      #1;
      check_resp(vecs[i].name, sample(), vecs[i].r, 1'b1);
    end
    check("table.valid", bus.valid, 4'b1111);
    s = '0;
    apply(s);
    clk_run = 1'b1;
    tick();
    check("resume.valid", bus.valid, 4'b1111);

    // Load-use: one bubble, then MEM/WB forwarding of the load result.
    s = '0; s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8; s.id_rt = 1; s.id_uses_rt = 1;
    apply(s);
    #1;
    check("lu.pc_en", bus.pc_en, 1'b0);
    check("lu.if_id_en", bus.if_id_en, 1'b0);
    check("lu.id_ex_en", bus.id_ex_en, 1'b1);
    tick();
    check("lu.bubble_valid", bus.valid, 4'b1011);
    check("lu.single_bubble", bus.pc_en, 1'b1);
    tick();
    check("lu.after_valid", bus.valid, 4'b1101);
    s = '0; s.ex_rs = 8; s.ex_rt = 1; s.mem_dest = 8; s.mem_reg_write = 1; s.wb_dest = 8; s.wb_reg_write = 1;
    apply(s);
    #1;
    check("lu.fwd_a_wb", bus.fwd_a, 2'b01);

    // Redirect from MEM squashes the younger instructions, including a store.
    s = '0; apply(s);
    repeat (3) tick();
    check("redir.pre_valid", bus.valid, 4'b1111);
    s.mem_redirect = 1;
    apply(s);
    #1;
    check("redir.sel", bus.pc_sel_redirect, 1'b1);
    check("redir.pc_en", bus.pc_en, 1'b1);
    tick();
    check("redir.valid", bus.valid, 4'b0001);
    s = '0; s.mem_write_raw = 1; s.ex_rs = 3; s.mem_dest = 3; s.mem_reg_write = 1;
    apply(s);
    #1;
    check("redir.squashed_sw", bus.mem_write, 1'b0);
    check("redir.no_fwd", bus.fwd_a, 2'b00);
    tick();
    check("redir.refetch_valid", bus.valid, 4'b1000);

    // Three busy cycles with redirect and load-use pending; redirect wins on the fourth.
    s = '0; apply(s);
    repeat (3) tick();
    check("frz.pre_valid", bus.valid, 4'b1111);
    s.mem_redirect = 1; s.dmem_busy = 1; s.ex_mem_read = 1; s.ex_rt = 5; s.id_rs = 5; s.mem_write_raw = 1;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("frz%0d.enables", i),
            {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 5'b00000);
      check($sformatf("frz%0d.mem_write", i), bus.mem_write, 1'b0);
      tick();
      check($sformatf("frz%0d.valid", i), bus.valid, 4'b1111);
    end
    s.dmem_busy = 0;
    apply(s);
    #1;
    check("frz.release_sel", bus.pc_sel_redirect, 1'b1);
    check("frz.release_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 5'b11111);
    tick();
    check("frz.release_valid", bus.valid, 4'b0001);

    // Asynchronous reset in the middle of a freeze.
    s = '0; apply(s);
    repeat (4) tick();
    check("rstfrz.pre_valid", bus.valid, 4'b1111);
    s.dmem_busy = 1; s.mem_write_raw = 1; s.wb_reg_write = 1;
    apply(s);
    tick();
    check("rstfrz.held_valid", bus.valid, 4'b1111);
    #2 reset = 1'b0;
    #1;
    check("rstfrz.valid", bus.valid, 4'b0000);
    check("rstfrz.mem_write", bus.mem_write, 1'b0);
    check("rstfrz.reg_write", bus.reg_write, 1'b0);
    check("rstfrz.pc_en", bus.pc_en, 1'b1);
    tick();
    reset = 1'b1;

    // Random stimulus against the occupancy model.
    for (int i = 0; i < 4; i++) occ[i] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      s.id_rs         = 5'($urandom_range(0, 3));
      s.id_rt         = 5'($urandom_range(0, 3));
      s.id_uses_rt    = 1'($urandom_range(0, 1));
      s.ex_rs         = 5'($urandom_range(0, 3));
      s.ex_rt         = 5'($urandom_range(0, 3));
      s.ex_mem_read   = ($urandom_range(0, 2) == 0);
      s.mem_dest      = 5'($urandom_range(0, 3));
      s.mem_reg_write = 1'($urandom_range(0, 1));
      s.mem_write_raw = 1'($urandom_range(0, 1));
      s.mem_redirect  = ($urandom_range(0, 7) == 0);
      s.dmem_busy     = ($urandom_range(0, 5) == 0);
      s.wb_dest       = 5'($urandom_range(0, 3));
      s.wb_reg_write  = 1'($urandom_range(0, 1));
      apply(s);
      #1;
      exp_r = model_resp(s);
      check($sformatf("rnd%0d.valid", n), bus.valid, occ_bits());
      check_resp($sformatf("rnd%0d", n), sample(), exp_r, model_kind(s) != 3);
      model_step(s);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
